matvec_row_sequencer: RTL and testbench
=======================================

MATVEC_ROW_SEQUENCER -- requirements
Module: matvec_row_sequencer

Interface
REQ-001 Parameter NUM_PE, default 16: number of chained processing elements; sets the drain length.
REQ-002 Parameter MAX_LEN, default 16: maximum vector length, equal to the FIFO depth.
REQ-003 Parameter LEN_W, default 5: width of vec_len, wide enough to hold MAX_LEN.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-005 clk  in  1  sole clock; all state changes on the rising edge.
REQ-006 rst  in  1  asynchronous, active-low reset.
REQ-007 start  in  1  single-cycle job request.
REQ-008 vec_len  in  LEN_W  element count per job, sampled with start.
REQ-009 in_valid  in  1  upstream data/weight pair available.
REQ-010 in_ready  out  1  sequencer accepts the pair this cycle.
REQ-011 fifo_full  in  1  full flag from the data/weight FIFOs.
REQ-012 fifo_empty  in  1  empty flag from the data/weight FIFOs.
REQ-013 fifo_wr_en  out  1  common write enable to all FIFOs.
REQ-014 fifo_rd_en  out  1  common read enable to all FIFOs.
REQ-015 pe_clear  out  1  one-cycle accumulator clear to all processing elements.
REQ-016 busy  out  1  high in every state except IDLE.
REQ-017 len_err  out  1  one-cycle pulse when a start is rejected.
REQ-018 result_valid  out  1  processing-element outputs are final.
REQ-019 result_ready  in  1  consumer has taken the results.

Function
REQ-020 States SHALL be IDLE, LOAD, COMPUTE, DRAIN and HOLD, held in a registered state variable.
REQ-021 Start acceptance: in IDLE, start=1 with 1 <= vec_len <= MAX_LEN SHALL latch vec_len, clear both counters and enter LOAD on the next edge.
REQ-022 On entry to LOAD, pe_clear SHALL be high for exactly the first LOAD cycle.
REQ-023 Rejected start: in IDLE, start=1 with vec_len=0 or vec_len>MAX_LEN SHALL stay in IDLE and pulse len_err for one cycle.
REQ-024 Start outside IDLE SHALL be ignored, with no len_err and no state change.
REQ-025 LOAD handshake: in_ready = ~fifo_full; fifo_wr_en = in_valid & ~fifo_full, combinational within the cycle.
REQ-026 LOAD count: each write SHALL increment load_cnt; the write that makes load_cnt equal the latched length SHALL move the block to COMPUTE on the next edge.
REQ-027 Outside LOAD, in_ready and fifo_wr_en SHALL be 0.
REQ-028 COMPUTE: fifo_rd_en = ~fifo_empty; each read SHALL increment rd_cnt.
REQ-029 If fifo_empty is high in COMPUTE, the block SHALL stall without leaving COMPUTE.
REQ-030 When the read that makes rd_cnt equal the latched length occurs, the block SHALL enter DRAIN on the next edge.
REQ-031 DRAIN SHALL last exactly NUM_PE cycles, covering forward-chain skew, then enter HOLD.
REQ-032 In DRAIN, fifo_rd_en SHALL be 0.
REQ-033 HOLD: result_valid SHALL be 1 and SHALL stay 1 until the cycle result_ready=1; the block then returns to IDLE on the next edge.
REQ-034 If result_ready is already 1 on the first HOLD cycle, result_valid SHALL be high for exactly one cycle.
REQ-035 Latency from accepted start to result_valid, with no stalls, SHALL be 1 + vec_len + vec_len + NUM_PE cycles.
REQ-036 Counters SHALL be LEN_W bits, SHALL never exceed the latched length and SHALL never wrap.

Reset
REQ-037 While rst=0, the block SHALL be in IDLE, with counters and latched length at 0.
REQ-038 While rst=0, all outputs SHALL be 0: in_ready, fifo_wr_en, fifo_rd_en, pe_clear, busy, len_err and result_valid.
REQ-039 Reset asserted mid-job SHALL abort the job immediately, with no result_valid and no pe_clear on release.
REQ-040 The FIFOs share the same rst and flush with the sequencer.
REQ-041 The first start is accepted on the first edge after rst deasserts.

Configuration
REQ-042 Macro MATVEC_SEQ_PERF_CNT_EN, when defined, SHALL add output perf_cycles [15:0].
REQ-043 perf_cycles SHALL clear on start acceptance, increment every busy cycle and saturate at 16'hFFFF.
REQ-044 perf_cycles SHALL freeze in IDLE and reset to 0.
REQ-045 Without MATVEC_SEQ_PERF_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-046 Nominal job: start with vec_len=16, in_valid held 1, FIFO never full or empty -> pe_clear at cycle 1, 16 writes, 16 reads, result_valid at cycle 49, perf_cycles=48 when MATVEC_SEQ_PERF_CNT_EN is defined.
REQ-047 Backpressure: vec_len=4, fifo_full forced high for 3 LOAD cycles -> in_ready and fifo_wr_en held 0 for those cycles, still exactly 4 writes, result_valid delayed by 3 cycles.
REQ-048 Empty stall and HOLD: vec_len=2, fifo_empty high for 5 COMPUTE cycles -> rd_en 0 for 5 cycles, exactly 2 reads; result_ready low for 10 cycles -> result_valid held 10 cycles.
REQ-049 Bad length: start with vec_len=0, then with vec_len=17 -> len_err pulses twice, busy stays 0; start during COMPUTE -> ignored.
REQ-050 Reset mid-job: rst=0 during DRAIN of a vec_len=8 job -> all outputs 0 immediately, IDLE; a new start with vec_len=1 completes in 1+1+1+16 = 19 cycles.

Source files
------------

// File: rtl/matvec_row_sequencer.sv
// matvec_row_sequencer
// Sequences one matrix-row job: loads vec_len data/weight pairs into the
// FIFOs, streams them out to the processing-element chain, waits NUM_PE
// cycles for the chain to drain, then holds result_valid until the consumer
// takes the results.
// Optional feature: define MATVEC_SEQ_PERF_CNT_EN to add the perf_cycles
// busy-cycle counter output.
module matvec_row_sequencer #(
  parameter int NUM_PE  = 16,
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] vec_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             fifo_full,
  input  logic             fifo_empty,
  output logic             fifo_wr_en,
  output logic             fifo_rd_en,
  output logic             pe_clear,
  output logic             busy,
  output logic             len_err,
  output logic             result_valid,
  input  logic             result_ready
`ifdef MATVEC_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]      perf_cycles
`endif
);

  localparam int DRN_W = $clog2(NUM_PE + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_DRAIN   = 3'd3,
    ST_HOLD    = 3'd4
  } state_t;

  state_t             state_r;
  state_t             state_nxt_s;
  logic [LEN_W-1:0]   len_r;
  logic [LEN_W-1:0]   load_cnt_r;
  logic [LEN_W-1:0]   rd_cnt_r;
  logic [DRN_W-1:0]   drain_cnt_r;
  logic               pe_clear_r;
  logic               len_err_r;
  logic               len_ok_s;
  logic               accept_s;
  logic               reject_s;
  logic               wr_s;
  logic               rd_s;

  // Start qualification: only a length in 1..MAX_LEN starts a job from IDLE.
  always_comb begin
    len_ok_s = (vec_len != {LEN_W{1'b0}}) && (vec_len <= LEN_W'(MAX_LEN));
    accept_s = 1'b0;
    reject_s = 1'b0;
    if (state_r == ST_IDLE) begin
      accept_s = start & len_ok_s;
      reject_s = start & ~len_ok_s;
    end else begin
      accept_s = 1'b0;
      reject_s = 1'b0;
    end
  end

  // Next-state and handshake outputs; handshakes follow the FIFO flags within the cycle.
  always_comb begin
    state_nxt_s  = state_r;
    in_ready     = 1'b0;
    fifo_wr_en   = 1'b0;
    fifo_rd_en   = 1'b0;
    busy         = 1'b1;
    result_valid = 1'b0;
    wr_s         = 1'b0;
    rd_s         = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
        if (accept_s) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        in_ready   = ~fifo_full;
        wr_s       = in_valid & ~fifo_full;
        fifo_wr_en = wr_s;
        if (wr_s && ((load_cnt_r + LEN_W'(1)) == len_r)) begin
          state_nxt_s = ST_COMPUTE;
        end else begin
          state_nxt_s = ST_LOAD;
        end
      end
      ST_COMPUTE: begin
        rd_s       = ~fifo_empty;
        fifo_rd_en = rd_s;
        if (rd_s && ((rd_cnt_r + LEN_W'(1)) == len_r)) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_COMPUTE;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_r == DRN_W'(NUM_PE - 1)) begin
          state_nxt_s = ST_HOLD;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      ST_HOLD: begin
        result_valid = 1'b1;
        if (result_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_HOLD;
        end
      end
      default: begin
        busy        = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register; reset aborts any job in progress.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Latched length and load/read counters; counters stop at the latched length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len_r      <= {LEN_W{1'b0}};
      load_cnt_r <= {LEN_W{1'b0}};
      rd_cnt_r   <= {LEN_W{1'b0}};
    end else if (accept_s) begin
      len_r      <= vec_len;
      load_cnt_r <= {LEN_W{1'b0}};
      rd_cnt_r   <= {LEN_W{1'b0}};
    end else begin
      if (wr_s) begin
        load_cnt_r <= load_cnt_r + LEN_W'(1);
      end
      if (rd_s) begin
        rd_cnt_r <= rd_cnt_r + LEN_W'(1);
      end
    end
  end

  // Drain timer: counts the cycles spent waiting for the PE chain skew.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drain_cnt_r <= {DRN_W{1'b0}};
    end else if (state_r == ST_DRAIN) begin
      drain_cnt_r <= drain_cnt_r + DRN_W'(1);
    end else begin
      drain_cnt_r <= {DRN_W{1'b0}};
    end
  end

  // Registered pulses: accumulator clear on the first LOAD cycle, len_err after a rejected start.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pe_clear_r <= 1'b0;
      len_err_r  <= 1'b0;
    end else begin
      pe_clear_r <= accept_s;
      len_err_r  <= reject_s;
    end
  end

  assign pe_clear = pe_clear_r;
  assign len_err  = len_err_r;

`ifdef MATVEC_SEQ_PERF_CNT_EN
  logic [15:0] perf_cycles_r;

  // Busy-cycle counter: cleared on start, saturating, frozen while idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_cycles_r <= 16'h0000;
    end else if (accept_s) begin
      perf_cycles_r <= 16'h0000;
    end else if (busy && (perf_cycles_r != 16'hFFFF)) begin
      perf_cycles_r <= perf_cycles_r + 16'h0001;
    end else begin
      perf_cycles_r <= perf_cycles_r;
    end
  end

  assign perf_cycles = perf_cycles_r;
`endif

endmodule

// File: tb/tb_matvec_row_sequencer.sv
// Self-checking bench for matvec_row_sequencer. The reference model tracks a
// job as counts of writes, reads, drain cycles and stall cycles and derives
// every expected output and the result latency from those counts.
module tb_matvec_row_sequencer;
  localparam int NUM_PE  = 16;
  localparam int MAX_LEN = 16;
  localparam int LEN_W   = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [LEN_W-1:0] vec_len = '0;
  logic             in_valid = 1'b0;
  logic             fifo_full = 1'b0;
  logic             fifo_empty = 1'b0;
  logic             result_ready = 1'b0;
  logic             in_ready, fifo_wr_en, fifo_rd_en, pe_clear, busy, len_err, result_valid;
`ifdef MATVEC_SEQ_PERF_CNT_EN
  logic [15:0]      perf_cycles;
`endif

  int compared = 0;
  int mism = 0;

  matvec_row_sequencer #(.NUM_PE(NUM_PE), .MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_wr_en(fifo_wr_en), .fifo_rd_en(fifo_rd_en),
    .pe_clear(pe_clear), .busy(busy), .len_err(len_err),
    .result_valid(result_valid), .result_ready(result_ready)
`ifdef MATVEC_SEQ_PERF_CNT_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mism++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_wr_en"}, fifo_wr_en, 0);
    chk({tag, "_rd_en"}, fifo_rd_en, 0);
    chk({tag, "_pe_clear"}, pe_clear, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_len_err"}, len_err, 0);
    chk({tag, "_result_valid"}, result_valid, 0);
  endtask

  // One job: full_n / empty_n force the flag for the first N LOAD / COMPUTE
  // cycles, hold_n is the number of HOLD cycles with result_ready low,
  // rnd replaces the forced stalls with random ones.
  task automatic run_job(input int len, input int full_n, input int empty_n,
                         input int hold_n, input bit rnd);
    int writes = 0;
    int reads = 0;
    int stalls = 0;
    int cyc;
    int k;
    bit full_s, valid_s, empty_s;
    @(negedge clk);
    start = 1'b1; vec_len = LEN_W'(len); in_valid = 1'b0;
    fifo_full = 1'b0; fifo_empty = 1'b0; result_ready = 1'b0;
    #1 chk("idle_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    // LOAD phase: one cycle per attempted write until len writes are done
    while (writes < len) begin
      if (rnd) begin
        full_s  = ($urandom_range(0, 3) == 0);
        valid_s = ($urandom_range(0, 3) != 0);
      end else begin
        full_s  = (cyc <= full_n);
        valid_s = 1'b1;
      end
      fifo_full = full_s; in_valid = valid_s;
      fifo_empty = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1)); vec_len = LEN_W'($urandom);
      #1;
      chk("load_in_ready", in_ready, !full_s);
      chk("load_wr_en", fifo_wr_en, valid_s && !full_s);
      chk("load_rd_en", fifo_rd_en, 0);
      chk("load_pe_clear", pe_clear, cyc == 1);
      chk("load_busy", busy, 1);
      chk("load_rv", result_valid, 0);
      chk("load_len_err", len_err, 0);
      if (valid_s && !full_s) writes++; else stalls++;
      @(negedge clk); cyc++;
    end
    // COMPUTE phase
    k = 0;
    while (reads < len) begin
      empty_s = rnd ? ($urandom_range(0, 2) == 0) : (k < empty_n);
      fifo_empty = empty_s;
      fifo_full = 1'($urandom_range(0, 1)); in_valid = 1'($urandom_range(0, 1));
      start = 1'($urandom_range(0, 1)); vec_len = LEN_W'($urandom);
      #1;
      chk("comp_rd_en", fifo_rd_en, !empty_s);
      chk("comp_in_ready", in_ready, 0);
      chk("comp_wr_en", fifo_wr_en, 0);
      chk("comp_pe_clear", pe_clear, 0);
      chk("comp_busy", busy, 1);
      chk("comp_rv", result_valid, 0);
      chk("comp_len_err", len_err, 0);
      if (!empty_s) reads++; else stalls++;
      k++;
      @(negedge clk); cyc++;
    end
    // DRAIN phase: NUM_PE cycles, never reading
    for (int d = 0; d < NUM_PE; d++) begin
      fifo_empty = 1'b0; in_valid = 1'b1; fifo_full = 1'b0;
      start = 1'($urandom_range(0, 1)); vec_len = LEN_W'($urandom);
      #1;
      chk("drain_rd_en", fifo_rd_en, 0);
      chk("drain_wr_en", fifo_wr_en, 0);
      chk("drain_busy", busy, 1);
      chk("drain_rv", result_valid, 0);
      chk("drain_len_err", len_err, 0);
      @(negedge clk); cyc++;
    end
    // HOLD phase
    chk("latency", cyc, 1 + 2 * len + NUM_PE + stalls);
`ifdef MATVEC_SEQ_PERF_CNT_EN
    #1 chk("perf_cycles", perf_cycles, cyc - 1);
`endif
    for (int h = 0; h <= hold_n; h++) begin
      result_ready = (h == hold_n);
      start = 1'($urandom_range(0, 1)); vec_len = LEN_W'($urandom);
      #1;
      chk("hold_rv", result_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_rd_en", fifo_rd_en, 0);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_len_err", len_err, 0);
      @(negedge clk);
    end
    start = 1'b0; result_ready = 1'b0; in_valid = 1'b0;
    #1;
    chk("post_rv", result_valid, 0);
    chk("post_busy", busy, 0);
    chk("post_len_err", len_err, 0);
  endtask

  task automatic reject(input int v);
    @(negedge clk);
    start = 1'b1; vec_len = LEN_W'(v);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("rej_len_err", len_err, 1);
    chk("rej_busy", busy, 0);
    chk("rej_pe_clear", pe_clear, 0);
    @(negedge clk);
    #1;
    chk("rej_len_err_end", len_err, 0);
    chk("rej_busy_end", busy, 0);
  endtask

  initial begin
    // Reset state, with start asserted to show it is ignored under reset
    start = 1'b1; vec_len = LEN_W'(4); in_valid = 1'b1;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    start = 1'b0;
    @(posedge clk); #2 rst = 1'b1;

    run_job(16, 0, 0, 0, 1'b0);   // nominal job, latency 49
    run_job(4, 3, 0, 0, 1'b0);    // fifo_full for 3 LOAD cycles
    run_job(2, 0, 5, 10, 1'b0);   // fifo_empty for 5 COMPUTE cycles, 10-cycle hold
    reject(0);
    reject(17);
    reject(31);
    for (int j = 0; j < 6; j++) begin
      run_job($urandom_range(1, MAX_LEN), 0, 0, $urandom_range(0, 4), 1'b1);
    end
    run_job(MAX_LEN, 0, 0, 0, 1'b1);
    run_job(1, 0, 0, 0, 1'b0);

    // Reset during DRAIN of an 8-element job
    @(negedge clk);
    start = 1'b1; vec_len = LEN_W'(8); in_valid = 1'b1; fifo_full = 1'b0; fifo_empty = 1'b0;
    @(negedge clk);
    start = 1'b0;
    repeat (8 + 8 + 3) @(negedge clk);
    #1 chk("pre_abort_busy", busy, 1);
    chk("pre_abort_rd_en", fifo_rd_en, 0);
    #1 rst = 1'b0;
    #1 chk_all_zero("abort");
    @(posedge clk); #2 chk_all_zero("abort_held");
    @(posedge clk); #2 rst = 1'b1;
    #1 chk_all_zero("release");
    in_valid = 1'b0;
    run_job(1, 0, 0, 0, 1'b0);    // latency 19

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end
endmodule
